// File: rtl/pipe_ctrl.sv
// pipe_ctrl: sequencing controller for the 5-stage cached CPU.
// Drives the PC / stage-register write enables and bubble flushes, arbitrates the
// shared backing-memory fill port (D-side first) and counts stall cycles.
module pipe_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_miss,
    input  logic             mem_acc,
    input  logic             mem_miss,
    input  logic             ex_memread,
    input  logic [3:0]       ex_rd,
    input  logic [3:0]       id_rs,
    input  logic [3:0]       id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic             ex_branch_taken,
    input  logic             fill_ack,
    output logic             pc_we,
    output logic             s0_we,
    output logic             s1_we,
    output logic             s2_we,
    output logic             s3_we,
    output logic             s0_flush,
    output logic             s1_flush,
    output logic             flags_en,
    output logic             fill_req,
    output logic             fill_sel,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {StRun, StIfill, StDfill} state_t;

    state_t state;
    state_t next_state;
    logic   pending_d;
    logic   pending_d_next;
    logic   fill_req_r;
    logic   fill_sel_r;
    logic   dmiss;
    logic   lu;

    assign dmiss = mem_acc & mem_miss;
    assign lu    = ex_memread & (ex_rd != 4'd0) &
                   ((id_rs_used & (id_rs == ex_rd)) | (id_rt_used & (id_rt == ex_rd)));

    // Write enables, flushes and next-state decode; priority dmiss > branch > load-use > I-miss.
    always_comb begin
        pc_we          = 1'b1;
        s0_we          = 1'b1;
        s1_we          = 1'b1;
        s2_we          = 1'b1;
        s3_we          = 1'b1;
        s0_flush       = 1'b0;
        s1_flush       = 1'b0;
        next_state     = state;
        pending_d_next = pending_d;
        case (state)
            StRun: begin
                if (dmiss) begin
                    {pc_we, s0_we, s1_we, s2_we, s3_we} = 5'b0;
                    next_state = StDfill;
                end else if (ex_branch_taken) begin
                    // Wrong-path fetch is squashed, so a concurrent I-miss is dropped.
                    s0_flush = 1'b1;
                    s1_flush = 1'b1;
                end else if (lu) begin
                    pc_we    = 1'b0;
                    s0_we    = 1'b0;
                    s1_flush = 1'b1;
                end else if (if_miss) begin
                    pc_we      = 1'b0;
                    s0_flush   = 1'b1;
                    next_state = StIfill;
                end
            end
            StIfill: begin
                if (dmiss) begin
                    {pc_we, s0_we, s1_we, s2_we, s3_we} = 5'b0;
                    pending_d_next = 1'b1;
                end else if (ex_branch_taken) begin
                    s0_flush = 1'b1;
                    s1_flush = 1'b1;
                end else if (lu) begin
                    pc_we    = 1'b0;
                    s0_we    = 1'b0;
                    s1_flush = 1'b1;
                end else begin
                    pc_we    = 1'b0;
                    s0_flush = 1'b1;
                end
                if (fill_ack) begin
                    // Hand the port straight to a D-miss that queued behind the I-fill.
                    next_state     = pending_d ? StDfill : StRun;
                    pending_d_next = 1'b0;
                end
            end
            StDfill: begin
                {pc_we, s0_we, s1_we, s2_we, s3_we} = 5'b0;
                if (fill_ack) next_state = StRun;
            end
            default: next_state = StRun;
        endcase
        if (!rst) begin
            {pc_we, s0_we, s1_we, s2_we, s3_we} = 5'b0;
            s0_flush = 1'b0;
            s1_flush = 1'b0;
        end
    end

    assign flags_en = s2_we;
    assign fill_req = fill_req_r & rst;
    assign fill_sel = fill_sel_r & rst;

    // State register with the Moore fill-port outputs registered alongside it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= StRun;
            pending_d  <= 1'b0;
            fill_req_r <= 1'b0;
            fill_sel_r <= 1'b0;
        end else begin
            state      <= next_state;
            pending_d  <= pending_d_next;
            fill_req_r <= (next_state != StRun);
            fill_sel_r <= (next_state == StDfill);
        end
    end

    // Saturating count of cycles in which the PC did not advance.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if (!pc_we && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: table of per-cycle vectors checked through a
// scoreboard queue, plus a hand-written D-fill handshake with a bounded wait.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_miss, mem_acc, mem_miss, ex_memread;
    logic [3:0]  ex_rd, id_rs, id_rt;
    logic        id_rs_used, id_rt_used, ex_branch_taken, fill_ack;
    logic        pc_we, s0_we, s1_we, s2_we, s3_we, s0_flush, s1_flush, flags_en;
    logic        fill_req, fill_sel;
    logic [15:0] stall_cycles;
    logic        x_pc_we, x_s0_we, x_s1_we, x_s2_we, x_s3_we, x_s0_flush, x_s1_flush;
    logic        x_flags_en, x_fill_req, x_fill_sel;
    logic [2:0]  sat_stall;
    logic [9:0]  outs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .if_miss(if_miss), .mem_acc(mem_acc), .mem_miss(mem_miss),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .ex_branch_taken(ex_branch_taken),
        .fill_ack(fill_ack), .pc_we(pc_we), .s0_we(s0_we), .s1_we(s1_we), .s2_we(s2_we),
        .s3_we(s3_we), .s0_flush(s0_flush), .s1_flush(s1_flush), .flags_en(flags_en),
        .fill_req(fill_req), .fill_sel(fill_sel), .stall_cycles(stall_cycles)
    );

    // Narrow counter instance so saturation is reached within a short run.
    pipe_ctrl #(.CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .if_miss(if_miss), .mem_acc(mem_acc), .mem_miss(mem_miss),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .ex_branch_taken(ex_branch_taken),
        .fill_ack(fill_ack), .pc_we(x_pc_we), .s0_we(x_s0_we), .s1_we(x_s1_we),
        .s2_we(x_s2_we), .s3_we(x_s3_we), .s0_flush(x_s0_flush), .s1_flush(x_s1_flush),
        .flags_en(x_flags_en), .fill_req(x_fill_req), .fill_sel(x_fill_sel),
        .stall_cycles(sat_stall)
    );

    assign outs = {pc_we, s0_we, s1_we, s2_we, s3_we, s0_flush, s1_flush, flags_en,
                   fill_req, fill_sel};

    // Output word: {pc,s0,s1,s2,s3 we, s0_flush, s1_flush, flags_en, fill_req, fill_sel}
    localparam logic [9:0] O_RST  = 10'b00000_00_0_00;
    localparam logic [9:0] O_ALL  = 10'b11111_00_1_00;
    localparam logic [9:0] O_LU   = 10'b00111_01_1_00;
    localparam logic [9:0] O_BR   = 10'b11111_11_1_00;
    localparam logic [9:0] O_IM   = 10'b01111_10_1_00;
    localparam logic [9:0] O_FRZ  = 10'b00000_00_0_00;
    localparam logic [9:0] O_DF   = 10'b00000_00_0_11;
    localparam logic [9:0] O_IF   = 10'b01111_10_1_10;
    localparam logic [9:0] O_IFZ  = 10'b00000_00_0_10;
    localparam logic [9:0] O_IFLU = 10'b00111_01_1_10;
    localparam logic [9:0] O_IFBR = 10'b11111_11_1_10;

    typedef struct {
        string      name;
        logic       r, im, ma, mm, er;
        logic [3:0] rd, rs, rt;
        logic       ru, tu, br, ak;
        logic [9:0] eo;
        int         es;
        bit         cs;
    } vec_t;

    typedef struct {
        string      name;
        logic [9:0] eo;
        int         es;
        bit         cs;
    } exp_t;

    vec_t vecs[$];
    exp_t sbq[$];

    function automatic vec_t mk(input string n, input int unsigned r, im, ma, mm, er,
                                input int unsigned rd, rs, rt, ru, tu, br, ak,
                                input logic [9:0] eo, input int es, input bit cs);
        vec_t v;
        v.name = n; v.r = 1'(r); v.im = 1'(im); v.ma = 1'(ma); v.mm = 1'(mm);
        v.er = 1'(er); v.rd = 4'(rd); v.rs = 4'(rs); v.rt = 4'(rt); v.ru = 1'(ru);
        v.tu = 1'(tu); v.br = 1'(br); v.ak = 1'(ak); v.eo = eo; v.es = es; v.cs = cs;
        return v;
    endfunction

    task automatic check_top();
        exp_t e;
        int   sat_exp;
        e = sbq.pop_front();
        checks++;
        if (outs !== e.eo) begin
            errors++;
            $display("FAIL %s outs: got %b expected %b", e.name, outs, e.eo);
        end
        if (e.cs) begin
            sat_exp = (e.es > 7) ? 7 : e.es;
            checks += 2;
            if (stall_cycles !== 16'(e.es)) begin
                errors++;
                $display("FAIL %s stall_cycles: got %0d expected %0d", e.name, stall_cycles,
                         e.es);
            end
            if (sat_stall !== 3'(sat_exp)) begin
                errors++;
                $display("FAIL %s sat_stall: got %0d expected %0d", e.name, sat_stall, sat_exp);
            end
        end
    endtask

    task automatic step(input vec_t v);
        exp_t e;
        rst = v.r; if_miss = v.im; mem_acc = v.ma; mem_miss = v.mm; ex_memread = v.er;
        ex_rd = v.rd; id_rs = v.rs; id_rt = v.rt; id_rs_used = v.ru; id_rt_used = v.tu;
        ex_branch_taken = v.br; fill_ack = v.ak;
        e.name = v.name; e.eo = v.eo; e.es = v.es; e.cs = v.cs;
        sbq.push_back(e);
        @(negedge clk);
        check_top();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        bit got;
        //                 name          r im ma mm er rd rs rt ru tu br ak  out    stall chk
        vecs.push_back(mk("rst_a",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RST,  0, 0));
        vecs.push_back(mk("rst_b",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RST,  0, 1));
        vecs.push_back(mk("idle",        1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_ALL,  0, 1));
        vecs.push_back(mk("lu_rs",       1, 0, 0, 0, 1, 5, 5, 0, 1, 0, 0, 0, O_LU,   0, 1));
        vecs.push_back(mk("after_lu",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_ALL,  1, 1));
        vecs.push_back(mk("lu_rd0",      1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, O_ALL,  1, 1));
        vecs.push_back(mk("lu_unused",   1, 0, 0, 0, 1, 5, 5, 0, 0, 0, 0, 0, O_ALL,  1, 1));
        vecs.push_back(mk("lu_rt",       1, 0, 0, 0, 1, 7, 3, 7, 1, 1, 0, 0, O_LU,   1, 1));
        vecs.push_back(mk("no_load",     1, 0, 0, 0, 0, 5, 5, 0, 1, 0, 0, 0, O_ALL,  2, 1));
        vecs.push_back(mk("dmiss_run",   1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, O_FRZ,  2, 1));
        vecs.push_back(mk("dfill_1",     1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, O_DF,   3, 1));
        vecs.push_back(mk("dfill_2",     1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, O_DF,   4, 1));
        vecs.push_back(mk("dfill_3",     1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, O_DF,   5, 1));
        vecs.push_back(mk("dfill_ack",   1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, O_DF,   6, 1));
        vecs.push_back(mk("dhit",        1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_ALL,  7, 1));
        vecs.push_back(mk("miss_no_acc", 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, O_ALL,  7, 1));
        vecs.push_back(mk("br_im_lu",    1, 1, 0, 0, 1, 5, 5, 0, 1, 0, 1, 0, O_BR,   7, 1));
        vecs.push_back(mk("after_br",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_ALL,  7, 1));
        vecs.push_back(mk("imiss",       1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_IM,   7, 1));
        vecs.push_back(mk("ifill_1",     1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_IF,   8, 1));
        vecs.push_back(mk("ifill_dmiss", 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, O_IFZ,  9, 1));
        vecs.push_back(mk("ifill_ack_d", 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, O_IFZ, 10, 1));
        vecs.push_back(mk("handoff_d",   1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, O_DF,  11, 1));
        vecs.push_back(mk("handoff_ack", 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, O_DF,  12, 1));
        vecs.push_back(mk("run_again",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_ALL, 13, 1));
        vecs.push_back(mk("imiss_2",     1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_IM,  13, 1));
        vecs.push_back(mk("ifill_lu",    1, 0, 0, 0, 1, 5, 5, 0, 1, 0, 0, 0, O_IFLU, 14, 1));
        vecs.push_back(mk("ifill_br",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_IFBR, 15, 1));
        vecs.push_back(mk("ifill_ack",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, O_IF,  15, 1));
        vecs.push_back(mk("run_3",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_ALL, 16, 1));
        vecs.push_back(mk("stray_ack",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, O_ALL, 16, 1));
        vecs.push_back(mk("dmiss_2",     1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, O_FRZ, 16, 1));
        vecs.push_back(mk("dfill_b",     1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, O_DF,  17, 1));
        vecs.push_back(mk("rst_in_df",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RST, 18, 1));
        vecs.push_back(mk("post_rst_ak", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, O_ALL,  0, 1));
        vecs.push_back(mk("post_rst",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_ALL,  0, 1));

        foreach (vecs[i]) step(vecs[i]);

        // D-miss handshake driven by waiting on the DUT's fill request.
        step(mk("hs_dmiss", 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, O_FRZ, 0, 1));
        got = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (fill_req === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!(got && fill_sel === 1'b1)) begin
            errors++;
            $display("FAIL hs_wait: got fill_req=%b fill_sel=%b expected 1 1", fill_req,
                     fill_sel);
        end
        fill_ack = 1'b1;
        @(posedge clk);
        #1;
        fill_ack = 1'b0;
        mem_miss = 1'b0;
        sbq.push_back('{name: "hs_done", eo: O_ALL, es: 2, cs: 1'b1});
        @(negedge clk);
        check_top();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the 5-stage cached CPU. It owns the write enables of the PC and of the four stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB), and requests bubbles for load-use hazards and taken branches. It arbitrates the single backing-memory fill port between I-cache and D-cache misses, with D-side priority. It also gates the EX/MEM flag write enables and counts stall cycles.

## Interface
Parameters:
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- if_miss  in  1  I-cache miss for the current fetch.
- mem_acc  in  1  MEM-stage instruction is a load or store (from EX/MEM mem signals).
- mem_miss  in  1  D-cache miss; only meaningful when mem_acc=1.
- ex_memread  in  1  EX-stage instruction is a load.
- ex_rd  in  4  EX-stage destination register.
- id_rs, id_rt  in  4 each  ID-stage source registers.
- id_rs_used, id_rt_used  in  1 each  the corresponding source is actually read.
- ex_branch_taken  in  1  a branch or jump resolved taken in EX.
- fill_ack  in  1  one-cycle pulse: the backing-memory fill has completed.
- pc_we, s0_we, s1_we, s2_we, s3_we  out  1 each  PC and stage-register write enables.
- s0_flush, s1_flush  out  1 each  the top level muxes a NOP/zero word into the IF/ID (s0) or ID/EX (s1) input. A flush is effective only when the matching we=1.
- flags_en  out  1  equal to s2_we; ANDed at the top level with the decoded flags_ctl.
- fill_req  out  1  fill-port request; held high until fill_ack.
- fill_sel  out  1  0 = I-cache fill, 1 = D-cache fill.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_we=0.

## Operation
Registered state:
- FSM: RUN, IFILL, DFILL.
- pending_d: 1 bit.
- stall_cycles.

Reset (rst=0 at a clock edge):
- state=RUN, pending_d=0, stall_cycles=0.
- While rst=0, all we, flush, fill_req and fill_sel outputs are forced to 0.

Definitions:
- dmiss = mem_acc & mem_miss.
- lu = ex_memread & (ex_rd≠0) & ((id_rs_used & id_rs==ex_rd) | (id_rt_used & id_rt==ex_rd)).

RUN (fill_req=0). Conditions are evaluated in priority order; the first match applies:
1. dmiss: all five we=0 (full freeze). Next state DFILL.
2. ex_branch_taken: all we=1, s0_flush=1, s1_flush=1. If if_miss is also set, it is ignored this cycle (the wrong-path fetch is squashed).
3. lu: pc_we=0, s0_we=0, s1_we=1 with s1_flush=1, s2_we=1, s3_we=1.
4. if_miss: pc_we=0, s0_we=1 with s0_flush=1, s1_we=s2_we=s3_we=1. Next state IFILL.
5. Otherwise: all we=1, no flush.

IFILL (fill_req=1, fill_sel=0):
- pc_we=0; s0_we=1 with s0_flush=1; downstream stages advance. The lu and ex_branch_taken rules from RUN apply unchanged.
  - A taken branch asserts pc_we=1 and both flushes. The fill in flight completes anyway.
- dmiss: full freeze, pending_d set to 1.
- On fill_ack:
  - pending_d=1 → next state DFILL; pending_d cleared.
  - pending_d=0 → next state RUN. The fetch is retried and hits.

DFILL (fill_req=1, fill_sel=1):
- Full freeze, all we=0.
- On fill_ack → next state RUN. The MEM access re-evaluates and hits.
- An I-miss during DFILL is not latched; it is re-detected in RUN.

Other rules:
- fill_ack while fill_req=0 is ignored.
- stall_cycles increments by 1 on every cycle (rst=1) with pc_we=0 and holds at 2^CNT_W−1.

## Timing
- All we, flush and flags_en outputs are combinational from the current state and inputs, valid within the same cycle.
- fill_req and fill_sel are Moore outputs of the state.
- D-miss:
  - Detected in cycle N, which is itself frozen.
  - fill_req=1 from cycle N+1 through the cycle of fill_ack (cycle A).
  - RUN at A+1; the load/store completes and the pipeline advances in A+1.
  - Total penalty = A−N+1 frozen cycles.
- I-miss: the bubble enters IF/ID at N; fill_req=1 from N+1 to A; the refetch happens in A+1.
- IFILL→DFILL handoff: fill_req stays high and fill_sel changes 0→1 on the edge after fill_ack, with no idle cycle.
- Reset asserted mid-fill: on the next edge the state returns to RUN and fill_req drops. The backing memory must discard the outstanding fill.

## Test plan
- Load-use: ex_memread=1, ex_rd=5, id_rs=5, id_rs_used=1 → exactly one cycle with pc_we=0, s0_we=0, s1_flush=1; stall_cycles 0→1.
- Same as above but with ex_rd=0, or with id_rs_used=0 → no stall; all we=1.
- D-miss with fill_ack 4 cycles after fill_req rises → 5 frozen cycles with flags_en=0, fill_sel=1; RUN afterwards; stall_cycles=5.
- I-miss at cycle N, then dmiss at N+2, fill_ack at N+3 → fill_sel goes 0→1 at N+4 with fill_req continuously high; DFILL is entered; pending_d clears.
- Taken branch in the same cycle as if_miss and lu → both flushes set, pc_we=1; state remains RUN.
- rst=0 during DFILL → next cycle state RUN, fill_req=0, stall_cycles=0; fill_ack arriving afterwards is ignored.
